// File: rtl/VX_gpu_pkg.sv
// Shared writeback packet definition for the commit -> register file path.
// Field widths here fix the width of the writeback channel.
// Packet is pure data; no handshake fields live in the struct.
package VX_gpu_pkg;

   localparam int NUM_THREADS = 4;
   localparam int XLEN        = 32;
   localparam int NR_BITS     = 5;
   localparam int ISSUE_WIS_W = 2;
   localparam int UUID_W      = 8;
   localparam int PC_W        = 32;
   localparam int INFL_W      = 4;
   localparam int NUM_WIS     = 1 << ISSUE_WIS_W;

   typedef struct packed {
      logic [UUID_W-1:0]           uuid;
      logic [ISSUE_WIS_W-1:0]      wis;
      logic [NUM_THREADS-1:0]      tmask;
      logic [PC_W-1:0]             pc;
      logic [NR_BITS-1:0]          rd;
      logic [NUM_THREADS*XLEN-1:0] data;
      logic                        sop;
      logic                        eop;
      logic [INFL_W-1:0]           infl_id;
   } wb_pkt_t;

   localparam int WB_DATAW = $bits(wb_pkt_t);

   // A new packet must open a sequence exactly when none is in flight.
   function automatic logic seq_violation(input logic sop, input logic open_pkt);
      return sop == open_pkt;
   endfunction

endpackage

// File: rtl/vx_wb_fifo.sv
// Small synchronous FIFO for writeback packets.
// Latency: push visible at the head one cycle later, no bypass.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is refused.
module vx_wb_fifo #(
   parameter int DATAW     = 8,
   parameter int DEPTH     = 4,
   parameter int AF_MARGIN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [DATAW-1:0] push_dat,
   input  logic             pop,
   output logic             push_ok,
   output logic             head_vld,
   output logic [DATAW-1:0] head_dat,
   output logic             almost_full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);

   logic [DATAW-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             full, pop_ok;

   assign full        = (count == FULL_LVL);
   assign head_vld    = (count != '0);
   assign pop_ok      = pop & head_vld;
   // A same-cycle pop frees the slot the push needs.
   assign push_ok     = push & (~full | pop_ok);
   assign head_dat    = mem[rd_ptr];
   assign almost_full = (count >= AF_LVL);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/vx_writeback_sink.sv
// Writeback sink: buffers packets, drains to the GPR port, releases scoreboard on eop.
// Latency: push -> gpr_wr_valid 1 cycle; pop -> release_valid 1 cycle.
// Backpressure: gpr_wr_ready stalls the head; upstream is throttled only via almost_full.
module vx_writeback_sink
   import VX_gpu_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int AF_MARGIN = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wb_valid,
   input  logic [WB_DATAW-1:0]         wb_data,
   output logic                        gpr_wr_valid,
   input  logic                        gpr_wr_ready,
   output logic [ISSUE_WIS_W-1:0]      gpr_wr_wis,
   output logic [NR_BITS-1:0]          gpr_wr_rd,
   output logic [NUM_THREADS-1:0]      gpr_wr_tmask,
   output logic [NUM_THREADS*XLEN-1:0] gpr_wr_data,
   output logic                        release_valid,
   output logic [ISSUE_WIS_W-1:0]      release_wis,
   output logic [NR_BITS-1:0]          release_rd,
   output logic                        almost_full,
   output logic                        overflow_err,
   output logic                        seq_err,
   output logic [31:0]                 commit_count
);

   wb_pkt_t             wb_pkt, head;
   logic [WB_DATAW-1:0] head_dat;
   logic                head_vld, push_ok, pop;
   logic [NUM_WIS-1:0]  in_pkt;
   logic                unused_dbg;

   assign wb_pkt = wb_data;

   vx_wb_fifo #(
      .DATAW     (WB_DATAW),
      .DEPTH     (DEPTH),
      .AF_MARGIN (AF_MARGIN)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (wb_valid),
      .push_dat    (wb_data),
      .pop         (pop),
      .push_ok     (push_ok),
      .head_vld    (head_vld),
      .head_dat    (head_dat),
      .almost_full (almost_full)
   );

   assign head         = head_dat;
   assign pop          = head_vld & gpr_wr_ready;
   assign gpr_wr_valid = head_vld;
   assign gpr_wr_wis   = head.wis;
   assign gpr_wr_rd    = head.rd;
   assign gpr_wr_tmask = head.tmask;
   assign gpr_wr_data  = head.data;

   // Trace-only fields travel through the FIFO but have no consumer here.
   assign unused_dbg = ^{head.uuid, head.pc, head.infl_id, head.sop};

   always_ff @(posedge clk) begin
      if (reset) begin
         in_pkt        <= '0;
         release_valid <= 1'b0;
         release_wis   <= '0;
         release_rd    <= '0;
         overflow_err  <= 1'b0;
         seq_err       <= 1'b0;
         commit_count  <= '0;
      end else begin
         release_valid <= pop & head.eop;
         if (pop & head.eop) begin
            release_wis <= head.wis;
            release_rd  <= head.rd;
         end
         // Dropped packets never touch the sequence tracker.
         if (push_ok) begin
            if (seq_violation(wb_pkt.sop, in_pkt[wb_pkt.wis])) seq_err <= 1'b1;
            in_pkt[wb_pkt.wis] <= ~wb_pkt.eop;
         end
         if (wb_valid & ~push_ok) overflow_err <= 1'b1;
         if (pop) commit_count <= commit_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_vx_writeback_sink.sv
// Directed bench for vx_writeback_sink with a queue-based reference model.
module tb_vx_writeback_sink;
   import VX_gpu_pkg::*;

   localparam int DEPTH     = 4;
   localparam int AF_MARGIN = 1;

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        wb_valid;
   logic [WB_DATAW-1:0]         wb_data;
   logic                        gpr_wr_valid;
   logic                        gpr_wr_ready;
   logic [ISSUE_WIS_W-1:0]      gpr_wr_wis;
   logic [NR_BITS-1:0]          gpr_wr_rd;
   logic [NUM_THREADS-1:0]      gpr_wr_tmask;
   logic [NUM_THREADS*XLEN-1:0] gpr_wr_data;
   logic                        release_valid;
   logic [ISSUE_WIS_W-1:0]      release_wis;
   logic [NR_BITS-1:0]          release_rd;
   logic                        almost_full;
   logic                        overflow_err;
   logic                        seq_err;
   logic [31:0]                 commit_count;

   vx_writeback_sink #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
      .clk          (clk),
      .reset        (reset),
      .wb_valid     (wb_valid),
      .wb_data      (wb_data),
      .gpr_wr_valid (gpr_wr_valid),
      .gpr_wr_ready (gpr_wr_ready),
      .gpr_wr_wis   (gpr_wr_wis),
      .gpr_wr_rd    (gpr_wr_rd),
      .gpr_wr_tmask (gpr_wr_tmask),
      .gpr_wr_data  (gpr_wr_data),
      .release_valid(release_valid),
      .release_wis  (release_wis),
      .release_rd   (release_rd),
      .almost_full  (almost_full),
      .overflow_err (overflow_err),
      .seq_err      (seq_err),
      .commit_count (commit_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a plain queue plus per-slot "open packet" flags.
   wb_pkt_t     mq[$];
   bit          m_open[NUM_WIS];
   bit          m_ovf, m_seq, m_rel_vld;
   int unsigned m_cnt;
   wb_pkt_t     m_rel;
   bit          chk_en = 0;

   always @(posedge clk) begin
      wb_pkt_t p, h;
      bit      popped;
      p = wb_data;
      if (reset) begin
         mq.delete();
         foreach (m_open[i]) m_open[i] = 0;
         m_ovf = 0; m_seq = 0; m_rel_vld = 0; m_cnt = 0;
      end else begin
         popped    = (mq.size() != 0) && gpr_wr_ready;
         m_rel_vld = 0;
         if (popped) begin
            h = mq.pop_front();
            m_cnt++;
            if (h.eop) begin m_rel_vld = 1; m_rel = h; end
         end
         if (wb_valid) begin
            if (mq.size() < DEPTH) begin
               if (p.sop && m_open[p.wis]) m_seq = 1;
               if (!p.sop && !m_open[p.wis]) m_seq = 1;
               m_open[p.wis] = !p.eop;
               mq.push_back(p);
            end else m_ovf = 1;
         end
      end
   end

   int          rel_seen = 0;
   logic [4:0]  last_rel_rd = '0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("gpr_wr_valid", gpr_wr_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("gpr_wr_wis", gpr_wr_wis, mq[0].wis);
            chk("gpr_wr_rd", gpr_wr_rd, mq[0].rd);
            chk("gpr_wr_tmask", gpr_wr_tmask, mq[0].tmask);
            chk("gpr_wr_data", gpr_wr_data, mq[0].data);
         end
         chk("almost_full", almost_full, mq.size() >= DEPTH - AF_MARGIN);
         chk("overflow_err", overflow_err, m_ovf);
         chk("seq_err", seq_err, m_seq);
         chk("commit_count", commit_count, m_cnt);
         chk("release_valid", release_valid, m_rel_vld);
         if (m_rel_vld) begin
            chk("release_wis", release_wis, m_rel.wis);
            chk("release_rd", release_rd, m_rel.rd);
         end
      end
      if (release_valid === 1'b1) begin
         rel_seen++;
         last_rel_rd = release_rd;
      end
   end

   function automatic wb_pkt_t mk(input int wis, input int rd, input bit sop, input bit eop, input int seed);
      wb_pkt_t p;
      p.uuid    = UUID_W'(seed);
      p.wis     = ISSUE_WIS_W'(wis);
      p.tmask   = NUM_THREADS'(seed) | 4'b0001;
      p.pc      = 32'h8000_0000 + 32'(seed * 4);
      p.rd      = NR_BITS'(rd);
      p.data    = {32'(seed) ^ 32'hA5A5_0000, 32'(seed * 3), 32'hDEAD_0000 + 32'(seed), ~32'(seed)};
      p.sop     = sop;
      p.eop     = eop;
      p.infl_id = INFL_W'(seed);
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input wb_pkt_t p);
      wb_valid = 1'b1;
      wb_data  = p;
      tick();
      wb_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int r0;

   initial begin
      reset = 1'b1; wb_valid = 1'b0; wb_data = '0; gpr_wr_ready = 1'b0;
      tick();
      chk_en = 1;
      tick();
      chk("reset gpr_wr_valid", gpr_wr_valid, 0);
      chk("reset commit_count", commit_count, 0);
      reset = 1'b0;
      tick();

      // Single packet through an empty FIFO.
      push(mk(2, 5, 1, 1, 1));
      chk("t1 valid after push", gpr_wr_valid, 1);
      chk("t1 head rd", gpr_wr_rd, 5);
      gpr_wr_ready = 1'b1;
      tick();
      chk("t1 release_valid", release_valid, 1);
      chk("t1 release_wis", release_wis, 2);
      chk("t1 release_rd", release_rd, 5);
      chk("t1 commit_count", commit_count, 1);
      tick();
      chk("t1 release drops", release_valid, 0);

      // Full FIFO with simultaneous push and pop.
      gpr_wr_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(mk(0, 10 + i, 1, 1, 20 + i));
      chk("t3 almost_full", almost_full, 1);
      r0 = rel_seen;
      gpr_wr_ready = 1'b1;
      push(mk(3, 20, 1, 1, 30));
      chk("t3 no overflow", overflow_err, 0);
      chk("t3 still almost_full", almost_full, 1);
      idle(7);
      chk("t3 releases", rel_seen - r0, 5);
      chk("t3 new packet last", last_rel_rd, 20);
      chk("t3 commit_count", commit_count, 6);

      // Fill, then overflow.
      gpr_wr_ready = 1'b0;
      push(mk(0, 1, 1, 1, 40));
      push(mk(0, 2, 1, 1, 41));
      chk("t2 af after 2", almost_full, 0);
      push(mk(0, 3, 1, 1, 42));
      chk("t2 af after 3", almost_full, 1);
      push(mk(0, 4, 1, 1, 43));
      push(mk(1, 9, 1, 0, 44));
      chk("t2 overflow_err", overflow_err, 1);
      r0 = rel_seen;
      gpr_wr_ready = 1'b1;
      idle(7);
      chk("t2 pops", rel_seen - r0, 4);
      chk("t2 last rd", last_rel_rd, 4);
      chk("t2 commit_count", commit_count, 10);

      // Interleaved multi-packet sequences on wis 0 and 3.
      r0 = rel_seen;
      push(mk(0, 6, 1, 0, 50));
      push(mk(3, 7, 1, 0, 51));
      push(mk(0, 6, 0, 0, 52));
      push(mk(3, 7, 0, 1, 53));
      push(mk(0, 6, 0, 1, 54));
      idle(4);
      chk("t5 seq_err", seq_err, 0);
      chk("t5 releases", rel_seen - r0, 2);
      chk("t5 last rd", last_rel_rd, 6);

      // Two-part packet on wis 1, then an orphan continuation.
      r0 = rel_seen;
      push(mk(1, 7, 1, 0, 60));
      push(mk(1, 8, 0, 1, 61));
      idle(3);
      chk("t4 seq_err clean", seq_err, 0);
      chk("t4 one release", rel_seen - r0, 1);
      chk("t4 release rd", last_rel_rd, 8);
      push(mk(1, 9, 0, 1, 62));
      chk("t4 seq_err set", seq_err, 1);
      idle(3);

      // Reset with entries queued and both flags set.
      gpr_wr_ready = 1'b0;
      push(mk(2, 11, 1, 0, 70));
      push(mk(0, 12, 1, 1, 71));
      push(mk(3, 13, 1, 1, 72));
      chk("t6 queued valid", gpr_wr_valid, 1);
      chk("t6 overflow before", overflow_err, 1);
      reset = 1'b1;
      wb_valid = 1'b1;
      wb_data = mk(1, 14, 1, 1, 73);
      tick();
      wb_valid = 1'b0;
      reset = 1'b0;
      chk("t6 gpr_wr_valid", gpr_wr_valid, 0);
      chk("t6 gpr_wr_wis", gpr_wr_wis, 0);
      chk("t6 gpr_wr_rd", gpr_wr_rd, 0);
      chk("t6 gpr_wr_tmask", gpr_wr_tmask, 0);
      chk("t6 gpr_wr_data", gpr_wr_data, 0);
      chk("t6 release_valid", release_valid, 0);
      chk("t6 release_wis", release_wis, 0);
      chk("t6 release_rd", release_rd, 0);
      chk("t6 almost_full", almost_full, 0);
      chk("t6 overflow_err", overflow_err, 0);
      chk("t6 seq_err", seq_err, 0);
      chk("t6 commit_count", commit_count, 0);
      push(mk(2, 15, 0, 1, 74));
      chk("t6 seq_err after reset", seq_err, 1);
      chk("t6 head wis", gpr_wr_wis, 2);
      gpr_wr_ready = 1'b1;
      idle(3);
      chk("t6 commit_count end", commit_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
